// File: rtl/wb_dma_gnt_pkg.sv
// Shared definitions for the channel grant controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the grant FSM state encoding, the width of a channel index as seen
// by the arbiter, and the default counter widths used by the controller and
// its beat counter.
package wb_dma_gnt_pkg;

   // A channel index on the arbiter interface is always 5 bits wide,
   // independent of how many channels are actually populated.
   localparam int CH_IDX_W  = 5;

   // Default chunk beat counter width (0 loaded means 2**DEF_CNT_W beats).
   localparam int DEF_CNT_W = 9;

   // Default watchdog width for the optional transfer timeout.
   localparam int DEF_TO_W  = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,   // waiting for a grant that points at a live request
      LOAD   = 3'd1,   // latch chunk size, kick the engine
      XFER   = 3'd2,   // counting engine beats
      ADV    = 3'd3,   // tell the arbiter to move on
      SETTLE = 3'd4    // arbiter updates gnt, nothing sampled
   } gnt_state_t;

endpackage

// File: rtl/wb_dma_chk_cnt.sv
// Chunk beat down-counter: loads a chunk size, decrements once per beat.
// Latency: load and decrement take effect on the next clk edge; flags are combinational from the count.
// Backpressure: none; dec is ignored once the count has reached zero.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset (count cleared)
//   load      - load load_val into the counter
//   load_val  - chunk size; a value of 0 is loaded as 2**CNT_W beats
//   dec       - one beat completed, decrement
//   zero      - count is zero (chunk exhausted / nothing loaded)
//   last      - count is one, so the next beat finishes the chunk
module wb_dma_chk_cnt
   import wb_dma_gnt_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero,
   output logic             last
);

   // One extra bit so that a zero chunk size can be represented as the full
   // 2**CNT_W beats without aliasing to "empty".
   logic [CNT_W:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         if (load_val == '0)
            cnt <= {1'b1, {CNT_W{1'b0}}};
         else
            cnt <= {1'b0, load_val};
      end else if (dec && !zero) begin
         cnt <= cnt - (CNT_W+1)'(1);
      end
   end

   assign zero = (cnt == '0);
   assign last = (cnt == (CNT_W+1)'(1));

endmodule

// File: rtl/wb_dma_ch_gnt_ctl.sv
// Requester side of the channel arbiter: registers requests, runs one chunk per grant, then pulses advance.
// Latency: req is ch_req delayed 1 cycle; xfer_start 1 cycle after a valid grant is seen; advance 1 cycle after the last beat or request drop.
// Backpressure: the engine paces beats with xfer_ack; without acks XFER holds (or aborts on the watchdog when WB_DMA_GNT_TIMEOUT_EN is defined).
//
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   ch_req      - per-channel service requests from the channel registers
//   req         - registered request vector towards the arbiter
//   gnt         - granted channel index from the arbiter
//   advance     - one-cycle pulse: arbiter should move to its next target
//   sel_ch      - channel being served, drives the register-file lookup
//   sel_chk_sz  - chunk size of sel_ch (combinational from the register file)
//   xfer_start  - one-cycle pulse: engine begins the chunk for sel_ch
//   xfer_ack    - engine finished one beat
//   busy        - a chunk is in progress (LOAD and XFER)
//   err         - watchdog abort pulse, valid together with sel_ch
//
// Optional build macro: WB_DMA_GNT_TIMEOUT_EN adds a TO_W-bit watchdog that
// aborts a chunk when the engine stops acknowledging beats. Without it err
// is tied low and XFER may wait forever.
//
// Turnaround per channel: IDLE -> LOAD -> XFER (n beats) -> ADV -> SETTLE.
module wb_dma_ch_gnt_ctl
   import wb_dma_gnt_pkg::*;
#(
   parameter int CH_NUM = 31,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int TO_W   = DEF_TO_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CH_NUM-1:0]   ch_req,
   output logic [CH_NUM-1:0]   req,
   input  logic [CH_IDX_W-1:0] gnt,
   output logic                advance,
   output logic [CH_IDX_W-1:0] sel_ch,
   input  logic [CNT_W-1:0]    sel_chk_sz,
   output logic                xfer_start,
   input  logic                xfer_ack,
   output logic                busy,
   output logic                err
);

   // The arbiter index space is 32 entries; anything else cannot be encoded.
   if (CH_NUM < 1 || CH_NUM > 32 || CNT_W < 1 || TO_W < 2) begin : g_bad_cfg
      $error("wb_dma_ch_gnt_ctl: unsupported CH_NUM/CNT_W/TO_W combination");
   end

   gnt_state_t state;

   // Requests widened to the full 32-entry index space. Unpopulated
   // channels read as 0, so a grant index >= CH_NUM is simply "not
   // requesting" and never indexes outside the vector.
   logic [31:0] req_pad;

   always_comb begin
      req_pad             = '0;
      req_pad[CH_NUM-1:0] = req;
   end

   logic gnt_hit;   // granted channel is actually requesting
   logic sel_req;   // served channel is still requesting

   assign gnt_hit = req_pad[gnt];
   assign sel_req = req_pad[sel_ch];

   // ------------------------------------------------------------------
   // Beat counter
   // ------------------------------------------------------------------
   logic cnt_zero;
   logic cnt_last;
   logic beat;

   // Beats only count while a chunk is running; stray acks elsewhere,
   // including the LOAD cycle, are dropped.
   assign beat = (state == XFER) && xfer_ack;

   wb_dma_chk_cnt #(
      .CNT_W    (CNT_W)
   ) u_chk_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (state == LOAD),
      .load_val (sel_chk_sz),
      .dec      (beat),
      .zero     (cnt_zero),
      .last     (cnt_last)
   );

   // cnt_zero cannot normally be seen in XFER (the counter is always loaded
   // with at least one beat); treating it as done keeps the FSM from
   // stalling on an empty counter.
   logic chunk_done;
   assign chunk_done = (state == XFER) && (cnt_zero || (beat && cnt_last));

   // ------------------------------------------------------------------
   // Optional watchdog
   // ------------------------------------------------------------------
   logic wd_expire;

`ifdef WB_DMA_GNT_TIMEOUT_EN
   logic [TO_W-1:0] wd;

   // The watchdog would reach all-ones on this edge: leave XFER on the same
   // edge so err and advance show up together in ADV, with sel_ch intact.
   assign wd_expire = (state == XFER) && !xfer_ack &&
                      (wd == {{(TO_W-1){1'b1}}, 1'b0});

   always_ff @(posedge clk) begin
      if (rst) begin
         wd  <= '0;
         err <= 1'b0;
      end else begin
         err <= wd_expire;
         if (state == LOAD || beat)
            wd <= '0;
         else if (state == XFER)
            wd <= wd + TO_W'(1);
      end
   end
`else
   assign wd_expire = 1'b0;
   assign err       = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Grant FSM, all outputs registered
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req        <= '0;
         advance    <= 1'b0;
         sel_ch     <= '0;
         xfer_start <= 1'b0;
         busy       <= 1'b0;
      end else begin
         req        <= ch_req;
         advance    <= 1'b0;
         xfer_start <= 1'b0;

         case (state)
            IDLE: begin
               if (gnt_hit) begin
                  sel_ch     <= gnt;
                  xfer_start <= 1'b1;
                  busy       <= 1'b1;
                  state      <= LOAD;
               end
            end

            // sel_chk_sz for the new sel_ch is valid now; the counter
            // loads it on this edge.
            LOAD: begin
               state <= XFER;
            end

            // Normal completion and a request drop lead to the same ADV,
            // so a last beat coinciding with the drop needs no special case.
            XFER: begin
               if (chunk_done || !sel_req || wd_expire) begin
                  advance <= 1'b1;
                  busy    <= 1'b0;
                  state   <= ADV;
               end
            end

            ADV: begin
               state <= SETTLE;
            end

            // Give the arbiter a cycle to present the next gnt before IDLE
            // looks at it again.
            SETTLE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_dma_ch_gnt_ctl.sv
// Bench for the channel grant controller: directed cases plus randomized chunks.
// Latency: expectations are derived as cycle numbers from request/grant/ack timing.
// Backpressure: the bench plays the engine, acknowledging beats at a random rate.
module tb_wb_dma_ch_gnt_ctl;
   import wb_dma_gnt_pkg::*;

   localparam int CH_NUM = 31;
   localparam int CNT_W  = 9;
   localparam int TO_W   = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [CH_NUM-1:0] ch_req;
   logic [CH_NUM-1:0] req;
   logic [4:0]        gnt;
   logic              advance;
   logic [4:0]        sel_ch;
   logic [CNT_W-1:0]  sel_chk_sz;
   logic              xfer_start;
   logic              xfer_ack;
   logic              busy;
   logic              err;

   // Bench-side register file: chunk size per channel, looked up by sel_ch.
   logic [CNT_W-1:0]  sz_tab [32];
   assign sel_chk_sz = sz_tab[sel_ch];

   always #5 clk = ~clk;

   wb_dma_ch_gnt_ctl #(
      .CH_NUM     (CH_NUM),
      .CNT_W      (CNT_W),
      .TO_W       (TO_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ch_req     (ch_req),
      .req        (req),
      .gnt        (gnt),
      .advance    (advance),
      .sel_ch     (sel_ch),
      .sel_chk_sz (sel_chk_sz),
      .xfer_start (xfer_start),
      .xfer_ack   (xfer_ack),
      .busy       (busy),
      .err        (err)
   );

   // Cycle t is the clock period following the t-th rising edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor, sampled mid-cycle.
   int         m_start = 0, m_adv = 0, m_busy = 0, m_err = 0;
   int         m_start_cyc = -1, m_adv_cyc = -1, m_err_cyc = -1;
   logic [4:0] m_start_sel = '0, m_err_sel = '0;

   always @(negedge clk) begin
      if (xfer_start === 1'b1) begin
         m_start     <= m_start + 1;
         m_start_cyc <= cyc;
         m_start_sel <= sel_ch;
      end
      if (advance === 1'b1) begin
         m_adv     <= m_adv + 1;
         m_adv_cyc <= cyc;
      end
      if (busy === 1'b1) m_busy <= m_busy + 1;
      if (err === 1'b1) begin
         m_err     <= m_err + 1;
         m_err_cyc <= cyc;
         m_err_sel <= sel_ch;
      end
   end

   int chk_cnt = 0;
   int err_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One chunk on channel ch. Reference rules: the chunk starts 2 cycles
   // after ch_req rises (1 cycle after gnt turns valid if the request is
   // already registered); beats are acks in cycles after the start cycle;
   // advance comes the cycle after the final beat, or 2 cycles after
   // ch_req[ch] drops, whichever is earlier. busy covers start..advance-1.
   task automatic run_chunk(input int ch, input int sz, input int ack_pct,
                            input int drop_off, input bit idle_first);
      int s0, a0, b0, e0, ps, d, need, beats, t, exp_adv;
      bit done;
      logic [31:0] r;
      need = (sz == 0) ? (1 << CNT_W) : sz;
      r = sz;
      sz_tab[ch] = r[CNT_W-1:0];
      s0 = m_start; a0 = m_adv; b0 = m_busy; e0 = m_err;
      if (idle_first) begin
         ch_req     = '0;
         ch_req[ch] = 1'b1;
         if (ch % 2 == 1) gnt = 5'd31;
         else begin
            r   = (ch + 1) % CH_NUM;
            gnt = r[4:0];
         end
         repeat (6) step();
         chk("no_start_on_idle_gnt", m_start - s0, 0);
         r   = ch;
         gnt = r[4:0];
         ps  = cyc + 1;
      end else begin
         r          = $urandom;
         ch_req     = r[CH_NUM-1:0];
         ch_req[ch] = 1'b1;
         r          = ch;
         gnt        = r[4:0];
         ps         = cyc + 2;
      end
      d       = (drop_off < 0) ? -1 : ps + drop_off;
      exp_adv = (drop_off < 0) ? 32'h3fff_ffff : d + 2;
      beats   = 0;
      done    = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         t = cyc;
         if (t >= exp_adv) begin
            ch_req = '0;
            r      = $urandom;
            gnt    = r[4:0];
         end else if (drop_off >= 0 && t >= d) begin
            ch_req[ch] = 1'b0;
         end
         xfer_ack = ($urandom_range(99) < ack_pct);
         if (xfer_ack && t > ps && t < exp_adv) begin
            beats++;
            if (beats == need) exp_adv = t + 1;
         end
         if (t >= exp_adv + 3) done = 1'b1;
         step();
      end
      xfer_ack = 1'b0;
      chk("chunk_budget", done, 1);
      chk("start_count", m_start - s0, 1);
      chk("start_cycle", m_start_cyc, ps);
      chk("start_sel_ch", m_start_sel, ch);
      chk("adv_count", m_adv - a0, 1);
      chk("adv_cycle", m_adv_cyc, exp_adv);
      chk("busy_cycles", m_busy - b0, exp_adv - ps);
      chk("err_count", m_err - e0, 0);
      chk("busy_after", busy, 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int s0, a0, e0, ps, ps2, t;
      for (int i = 0; i < 32; i++) sz_tab[i] = 9'd1;
      rst      = 1'b1;
      ch_req   = '0;
      gnt      = '0;
      xfer_ack = 1'b0;
      repeat (3) step();

      chk("rst_req", req, 0);
      chk("rst_advance", advance, 0);
      chk("rst_sel_ch", sel_ch, 0);
      chk("rst_xfer_start", xfer_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      repeat (2) step();

      // Basic chunk, gnt not requesting then valid, request drop,
      // drop coinciding with last beat, full-size chunk.
      run_chunk(0, 4, 100, -1, 1'b0);
      run_chunk(2, 3, 100, -1, 1'b1);
      run_chunk(3, 8, 100, 4, 1'b0);
      run_chunk(1, 4, 100, 3, 1'b0);
      run_chunk(7, 0, 100, -1, 1'b0);

      // Reset in the middle of a chunk, then the channel is served again
      // from its first beat.
      sz_tab[5]  = 9'd6;
      s0         = m_start;
      a0         = m_adv;
      ch_req     = '0;
      ch_req[5]  = 1'b1;
      gnt        = 5'd5;
      ps         = cyc + 2;
      xfer_ack   = 1'b1;
      while (cyc < ps + 3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_req", req, 0);
      chk("mid_rst_advance", advance, 0);
      chk("mid_rst_sel_ch", sel_ch, 0);
      chk("mid_rst_xfer_start", xfer_start, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_no_adv", m_adv - a0, 0);
      ps2 = ps + 6;
      while (cyc < ps2 + 10) begin
         if (cyc >= ps2 + 7) ch_req = '0;
         step();
      end
      xfer_ack = 1'b0;
      chk("rerun_start_count", m_start - s0, 2);
      chk("rerun_start_cycle", m_start_cyc, ps2);
      chk("rerun_adv_count", m_adv - a0, 1);
      chk("rerun_adv_cycle", m_adv_cyc, ps2 + 7);

      // Engine never acknowledges.
      sz_tab[9] = 9'd4;
      s0        = m_start;
      a0        = m_adv;
      e0        = m_err;
      ch_req    = '0;
      ch_req[9] = 1'b1;
      gnt       = 5'd9;
      ps        = cyc + 2;
      xfer_ack  = 1'b0;
`ifdef WB_DMA_GNT_TIMEOUT_EN
      while (cyc < ps + 259) begin
         if (cyc >= ps + 256) ch_req = '0;
         step();
      end
      chk("wd_err_count", m_err - e0, 1);
      chk("wd_err_cycle", m_err_cyc, ps + 256);
      chk("wd_err_sel_ch", m_err_sel, 9);
      chk("wd_adv_count", m_adv - a0, 1);
      chk("wd_adv_cycle", m_adv_cyc, ps + 256);
`else
      while (cyc < ps + 300) step();
      chk("stall_no_adv", m_adv - a0, 0);
      chk("stall_no_err", m_err - e0, 0);
      chk("stall_busy", busy, 1);
      chk("stall_err_low", err, 0);
      t        = cyc;
      xfer_ack = 1'b1;
      repeat (4) step();
      xfer_ack = 1'b0;
      ch_req   = '0;
      repeat (3) step();
      chk("stall_adv_count", m_adv - a0, 1);
      chk("stall_adv_cycle", m_adv_cyc, t + 4);
      chk("stall_err_count", m_err - e0, 0);
`endif
      chk("stall_start_count", m_start - s0, 1);
      repeat (2) step();

      // Randomized chunks.
      for (int n = 0; n < 20; n++) begin
         int ch, sz, pct, drp;
         bit idf;
         ch  = $urandom_range(30);
         sz  = $urandom_range(12, 1);
         pct = $urandom_range(100, 30);
         drp = ($urandom_range(1) == 0) ? -1 : $urandom_range(15);
         idf = $urandom_range(1) == 1;
         run_chunk(ch, sz, pct, drp, idf);
      end

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule
